// File: rtl/ahb_chk_pkg.sv
// Shared types and helpers for the AHB-Lite protocol checker.
package ahb_chk_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [3:0] {
    EC_NONE      = 4'd0,
    EC_STABLE    = 4'd1,
    EC_SEQ_ILL   = 4'd2,
    EC_BUSY_ILL  = 4'd3,
    EC_SEQ_ADDR  = 4'd4,
    EC_SEQ_CTRL  = 4'd5,
    EC_EARLY_TRM = 4'd6,
    EC_OVERRUN   = 4'd7,
    EC_KB_CROSS  = 4'd8,
    EC_SIZE      = 4'd9,
    EC_TIMEOUT   = 4'd10
  } err_code_e;

  typedef enum logic [1:0] {
    IDLE_ST  = 2'd0,
    BURST_ST = 2'd1,
    ERR_ST   = 2'd2
  } chk_state_e;

  // Control captured from the NONSEQ that opened a burst.
  typedef struct packed {
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [3:0] hprot;
  } ctrl_t;

  // Byte offsets below this mask share one 1KB page.
  localparam logic [31:0] KB_MASK = 32'h0000_03FF;

  // Fixed burst length in beats; 0 means no fixed length (SINGLE, INCR).
  function automatic logic [4:0] burst_len(input logic [2:0] hb);
    case (hb)
      HB_WRAP4, HB_INCR4:   burst_len = 5'd4;
      HB_WRAP8, HB_INCR8:   burst_len = 5'd8;
      HB_WRAP16, HB_INCR16: burst_len = 5'd16;
      default:              burst_len = 5'd0;
    endcase
  endfunction

  function automatic logic is_wrap(input logic [2:0] hb);
    is_wrap = (hb == HB_WRAP4) || (hb == HB_WRAP8) || (hb == HB_WRAP16);
  endfunction

  // Bit position of an error code inside err_vec.
  function automatic int err_bit(input err_code_e c);
    err_bit = int'(c) - 1;
  endfunction

endpackage

// File: rtl/ahb_protocol_checker_if.sv
// Snooped AHB-Lite slave-port signals. The master modport is the side that
// drives the observed bus (the system or a bench); the slave modport is the
// passive checker, which only reads.
//
// Handshake: a transfer is accepted on a rising hclk edge where
// hsel && hready && htrans[1]. While hready is low the address phase is held
// and the master must keep haddr/htrans/hwrite/hsize/hburst/hprot unchanged.
interface ahb_protocol_checker_if #(
  parameter int ADDR_W = 32
) ();
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hready;
  logic              hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hresp
  );

  modport slave (
    input hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hresp
  );
endinterface

// File: rtl/ahb_burst_addr_calc.sv
// Next expected SEQ address for INCR/WRAP bursts and the 1KB-cross flag
// for incrementing bursts. Purely combinational.
module ahb_burst_addr_calc
  import ahb_chk_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              kb_cross
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] linear;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] page_mask;

  // Linear increment, folded back into the wrap block for WRAP bursts.
  always_comb begin
    step      = ADDR_W'(1) << hsize;
    linear    = addr + step;
    wrap_mask = (ADDR_W'(burst_len(hburst)) << hsize) - ADDR_W'(1);
    page_mask = ~ADDR_W'(KB_MASK);
    if (is_wrap(hburst)) begin
      next_addr = (addr & ~wrap_mask) | (linear & wrap_mask);
    end else begin
      next_addr = linear;
    end
    kb_cross = !is_wrap(hburst) && ((next_addr & page_mask) != (addr & page_mask));
  end

endmodule

// File: rtl/ahb_protocol_checker.sv
// Passive AHB-Lite protocol checker for one slave port.
// Optional feature: define AHB_CHK_TIMEOUT_EN to enable the wait-state
// timeout (code 10); otherwise err_vec[9] is tied low.
module ahb_protocol_checker
  import ahb_chk_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16,
  parameter int NUM_ERR  = 10
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  ahb_protocol_checker_if.slave bus,
  input  logic                  err_clr,
  output logic                  err_valid,
  output logic [3:0]            err_code,
  output logic [NUM_ERR-1:0]    err_vec,
  output logic                  burst_active,
  output logic [4:0]            beat_cnt,
  output chk_state_e            dbg_state
);

  localparam int SIZE_MAX = $clog2(DATA_W / 8);

  logic              hsel, hwrite, hready, hresp;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [2:0]        hsize, hburst;
  logic [3:0]        hprot;
  ctrl_t             ctrl_cur;

  assign hsel     = bus.hsel;
  assign haddr    = bus.haddr;
  assign htrans   = bus.htrans;
  assign hwrite   = bus.hwrite;
  assign hsize    = bus.hsize;
  assign hburst   = bus.hburst;
  assign hprot    = bus.hprot;
  assign hready   = bus.hready;
  assign hresp    = bus.hresp;
  assign ctrl_cur = '{hwrite: hwrite, hsize: hsize, hburst: hburst, hprot: hprot};

  chk_state_e        state, state_n;
  logic [4:0]        beat_n;
  ctrl_t             rec, rec_n;
  logic [ADDR_W-1:0] prev_addr, prev_addr_n;

  // Last sampled control, for the stall-stability check.
  logic              stall_q;
  logic [ADDR_W-1:0] smp_addr;
  logic [1:0]        smp_trans;
  ctrl_t             smp_ctrl;

  logic [NUM_ERR-1:0] flags;
  logic [3:0]         code_n;
  logic               to_fire;

  logic [ADDR_W-1:0] exp_addr;
  logic              exp_kb_cross;

  ahb_burst_addr_calc #(.ADDR_W(ADDR_W)) u_addr_calc (
    .addr      (prev_addr),
    .hsize     (rec.hsize),
    .hburst    (rec.hburst),
    .next_addr (exp_addr),
    .kb_cross  (exp_kb_cross)
  );

  assign burst_active = (state == BURST_ST);
  assign dbg_state    = state;

`ifdef AHB_CHK_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  assign to_fire = hsel && !hready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // Consecutive selected wait states; saturates so the timeout fires once per stall.
  always_ff @(posedge hclk) begin
    if (!hresetn || !hsel || hready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  // Timeout disabled: MAX_WAIT has no effect in this build.
  assign to_fire = 1'b0 & (MAX_WAIT > 0);
`endif

  // Protocol checks and next-state for the burst tracker.
  always_comb begin
    logic       xfer;
    logic       acc;
    logic [4:0] len;
    logic       at_len;
    logic       fixed_open;

    flags       = '0;
    state_n     = state;
    beat_n      = beat_cnt;
    rec_n       = rec;
    prev_addr_n = prev_addr;
    xfer        = hsel && hready;
    acc         = xfer && htrans[1];
    len         = burst_len(rec.hburst);
    at_len      = (len != 5'd0) && (beat_cnt >= len);
    fixed_open  = (state == BURST_ST) && (len != 5'd0) && !at_len;

    // Control must not move while an address phase is held by hready low.
    if (stall_q && hsel &&
        ((haddr != smp_addr) || (htrans != smp_trans) || (ctrl_cur != smp_ctrl))) begin
      flags[err_bit(EC_STABLE)] = 1'b1;
    end

    // Second ERROR cycle must be hresp=1 with hready=1; the burst is dropped.
    if (state == ERR_ST) begin
      if (!(hresp && hready)) flags[err_bit(EC_STABLE)] = 1'b1;
      state_n = IDLE_ST;
      beat_n  = 5'd0;
    end

    if (xfer) begin
      case (htrans)
        HT_IDLE: begin
          if (state == BURST_ST) begin
            if (fixed_open) flags[err_bit(EC_EARLY_TRM)] = 1'b1;
            state_n = IDLE_ST;
            beat_n  = 5'd0;
          end
        end
        HT_BUSY: begin
          if (state != BURST_ST || hburst == HB_SINGLE) flags[err_bit(EC_BUSY_ILL)] = 1'b1;
          if (state == BURST_ST && ctrl_cur != rec) flags[err_bit(EC_SEQ_CTRL)] = 1'b1;
        end
        HT_NONSEQ: begin
          if (fixed_open) flags[err_bit(EC_EARLY_TRM)] = 1'b1;
          if (hburst != HB_SINGLE) begin
            state_n     = BURST_ST;
            beat_n      = 5'd1;
            rec_n       = ctrl_cur;
            prev_addr_n = haddr;
          end else begin
            state_n = IDLE_ST;
            beat_n  = 5'd0;
          end
        end
        default: begin
          if (state == IDLE_ST) begin
            flags[err_bit(EC_SEQ_ILL)] = 1'b1;
          end else if (state == BURST_ST) begin
            if (at_len) begin
              flags[err_bit(EC_OVERRUN)] = 1'b1;
            end else begin
              if (haddr != exp_addr) flags[err_bit(EC_SEQ_ADDR)] = 1'b1;
              if (ctrl_cur != rec)   flags[err_bit(EC_SEQ_CTRL)] = 1'b1;
              if (exp_kb_cross)      flags[err_bit(EC_KB_CROSS)] = 1'b1;
              beat_n      = (beat_cnt == 5'd31) ? beat_cnt : beat_cnt + 5'd1;
              prev_addr_n = haddr;
            end
          end
        end
      endcase
    end

    // Size legality and alignment of every accepted transfer.
    if (acc && ((hsize > 3'(SIZE_MAX)) ||
                ((haddr & ((ADDR_W'(1) << hsize) - ADDR_W'(1))) != '0))) begin
      flags[err_bit(EC_SIZE)] = 1'b1;
    end

    flags[err_bit(EC_TIMEOUT)] = to_fire;

    // First ERROR cycle: park in ERR_ST and drop any burst.
    if (hsel && hresp && !hready) begin
      state_n = ERR_ST;
      beat_n  = 5'd0;
    end
  end

  // Lowest-numbered error wins the reported code.
  always_comb begin
    code_n = 4'd0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (flags[i]) code_n = 4'(i + 1);
    end
  end

  // State, burst record and registered error reporting.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= IDLE_ST;
      beat_cnt  <= 5'd0;
      rec       <= '0;
      prev_addr <= '0;
      stall_q   <= 1'b0;
      smp_addr  <= '0;
      smp_trans <= 2'd0;
      smp_ctrl  <= '0;
      err_valid <= 1'b0;
      err_code  <= 4'd0;
      err_vec   <= '0;
    end else begin
      state     <= state_n;
      beat_cnt  <= beat_n;
      rec       <= rec_n;
      prev_addr <= prev_addr_n;
      stall_q   <= hsel && !hready && (htrans != HT_IDLE) && !hresp;
      smp_addr  <= haddr;
      smp_trans <= htrans;
      smp_ctrl  <= ctrl_cur;
      err_valid <= |flags;
      err_code  <= code_n;
      err_vec   <= (err_clr ? '0 : err_vec) | flags;
    end
  end

endmodule
